// File: rtl/atari_pkg.sv
// rtl/atari_pkg.sv - AN codes, decoder states and counter limits shared by the GTIA decoder
package atari_pkg;

  localparam logic [2:0] AN_BAK      = 3'b000;
  localparam logic [2:0] AN_VSYNC    = 3'b001;
  localparam logic [2:0] AN_HBLANK   = 3'b010;
  localparam logic [2:0] AN_VSYNC_HB = 3'b011;
  localparam logic [2:0] AN_PF0      = 3'b100;
  localparam logic [2:0] AN_PF1      = 3'b101;
  localparam logic [2:0] AN_PF2      = 3'b110;
  localparam logic [2:0] AN_PF3      = 3'b111;

  localparam logic [7:0] HPOS_MAX = 8'hFF;
  localparam logic [8:0] VPOS_MAX = 9'h1FF;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    ACTIVE    = 2'd1,
    HBLANK    = 2'd2,
    VSYNC     = 2'd3
  } dec_state_t;

  function automatic logic an_is_vsync(input logic [2:0] an);
    return (an == AN_VSYNC) || (an == AN_VSYNC_HB);
  endfunction

endpackage

// File: rtl/gtia_an_decoder_if.sv
// rtl/gtia_an_decoder_if.sv - ANTIC-side inputs and pixel/timing outputs of the GTIA decoder
interface gtia_an_decoder_if;
  logic [2:0] AN;
  logic       hires;
  logic [7:0] COLBK;
  logic [7:0] COLPF0;
  logic [7:0] COLPF1;
  logic [7:0] COLPF2;
  logic [7:0] COLPF3;
  logic [7:0] colorOut;
  logic [7:0] colorOut2;
  logic       pixelValid;
  logic       hsync;
  logic       frameStart;
  logic [7:0] hpos;
  logic [8:0] vpos;

  modport master (
    output AN, hires, COLBK, COLPF0, COLPF1, COLPF2, COLPF3,
    input  colorOut, colorOut2, pixelValid, hsync, frameStart, hpos, vpos
  );

  modport slave (
    input  AN, hires, COLBK, COLPF0, COLPF1, COLPF2, COLPF3,
    output colorOut, colorOut2, pixelValid, hsync, frameStart, hpos, vpos
  );
endinterface

// File: rtl/an_color_mux.sv
// rtl/an_color_mux.sv - combinational colour selection for one AN code, normal and hires
module an_color_mux
  import atari_pkg::*;
(
  input  logic [2:0] an,
  input  logic       hires,
  input  logic [7:0] colbk,
  input  logic [7:0] colpf0,
  input  logic [7:0] colpf1,
  input  logic [7:0] colpf2,
  input  logic [7:0] colpf3,
  output logic [7:0] color,
  output logic [7:0] color2
);

  // hires "on" half-pixel: playfield 2 hue with playfield 1 luma
  logic [7:0] hires_on;
  assign hires_on = {colpf2[7:4], colpf1[3:0]};

  always_comb begin
    color  = 8'h00;
    color2 = 8'h00;
    if (hires && an[2]) begin
      color  = an[1] ? hires_on : colpf2;
      color2 = an[0] ? hires_on : colpf2;
    end else begin
      case (an)
        AN_BAK:  color = colbk;
        AN_PF0:  color = colpf0;
        AN_PF1:  color = colpf1;
        AN_PF2:  color = colpf2;
        AN_PF3:  color = colpf3;
        default: color = 8'h00;
      endcase
      color2 = color;
    end
  end

endmodule

// File: rtl/gtia_an_decoder.sv
// rtl/gtia_an_decoder.sv - GTIA AN stream decoder: sync state machine, beam counters, registered pixel outputs
module gtia_an_decoder
  import atari_pkg::*;
(
  input logic              Fphi0,
  input logic              RST_L,
  gtia_an_decoder_if.slave bus
);

  dec_state_t state, state_nx;

  logic [7:0] mux_color, mux_color2;
  logic [7:0] color_d, color2_d, hpos_d;
  logic [8:0] vpos_d;
  logic       valid_d, hsync_d, frame_d;

  logic [7:0] color_q, color2_q, hpos_q;
  logic [8:0] vpos_q;
  logic       valid_q, hsync_q, frame_q;

  an_color_mux u_mux (
    .an     (bus.AN),
    .hires  (bus.hires),
    .colbk  (bus.COLBK),
    .colpf0 (bus.COLPF0),
    .colpf1 (bus.COLPF1),
    .colpf2 (bus.COLPF2),
    .colpf3 (bus.COLPF3),
    .color  (mux_color),
    .color2 (mux_color2)
  );

  always_ff @(posedge Fphi0 or negedge RST_L) begin
    if (!RST_L) state <= SYNC_WAIT;
    else        state <= state_nx;
  end

  // Once synchronised, every non-VSYNC code is either HBLANK or a pixel.
  always_comb begin
    state_nx = state;
    if (an_is_vsync(bus.AN))
      state_nx = VSYNC;
    else if (state != SYNC_WAIT)
      state_nx = (bus.AN == AN_HBLANK) ? HBLANK : ACTIVE;
  end

  always_comb begin
    color_d  = 8'h00;
    color2_d = 8'h00;
    valid_d  = 1'b0;
    hpos_d   = hpos_q;
    vpos_d   = vpos_q;
    hsync_d  = (state == ACTIVE) && (state_nx == HBLANK);
    frame_d  = (state != VSYNC) && (state_nx == VSYNC);
    if (state_nx == ACTIVE) begin
      valid_d  = 1'b1;
      color_d  = mux_color;
      color2_d = mux_color2;
      if (state != ACTIVE)
        hpos_d = 8'd0;
      else if (hpos_q != HPOS_MAX)
        hpos_d = hpos_q + 8'd1;
    end
    if (frame_d)
      vpos_d = 9'd0;
    else if (hsync_d && (vpos_q != VPOS_MAX))
      vpos_d = vpos_q + 9'd1;
  end

  always_ff @(posedge Fphi0 or negedge RST_L) begin
    if (!RST_L) begin
      color_q  <= 8'h00;
      color2_q <= 8'h00;
      valid_q  <= 1'b0;
      hsync_q  <= 1'b0;
      frame_q  <= 1'b0;
      hpos_q   <= 8'd0;
      vpos_q   <= 9'd0;
    end else begin
      color_q  <= color_d;
      color2_q <= color2_d;
      valid_q  <= valid_d;
      hsync_q  <= hsync_d;
      frame_q  <= frame_d;
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
    end
  end

  assign bus.colorOut   = color_q;
  assign bus.colorOut2  = color2_q;
  assign bus.pixelValid = valid_q;
  assign bus.hsync      = hsync_q;
  assign bus.frameStart = frame_q;
  assign bus.hpos       = hpos_q;
  assign bus.vpos       = vpos_q;

endmodule

// File: tb/tb_gtia_an_decoder.sv
// tb/tb_gtia_an_decoder.sv - scoreboard bench for gtia_an_decoder with a behavioural beam model
module tb_gtia_an_decoder;

  logic Fphi0 = 1'b0;
  logic RST_L;

  gtia_an_decoder_if bus ();

  gtia_an_decoder dut (
    .Fphi0 (Fphi0),
    .RST_L (RST_L),
    .bus   (bus)
  );

  always #5 Fphi0 = ~Fphi0;

  typedef struct {
    logic [7:0] c1;
    logic [7:0] c2;
    logic       valid;
    logic       hs;
    logic       fs;
    logic [7:0] hp;
    logic [8:0] vp;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int checks = 0;
  int failures = 0;

  // Beam model: where the beam is, as plain flags and integer counters.
  bit synced, in_vsync, in_blank;
  int m_h, m_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    synced = 0; in_vsync = 0; in_blank = 0; m_h = 0; m_v = 0;
  endtask

  task automatic drive_col(input logic [2:0] code, input logic hr, input logic [7:0] bk,
                           input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3);
    exp_t e;
    logic [7:0] pf [4];
    logic [7:0] on_c;
    @(negedge Fphi0);
    bus.AN = code; bus.hires = hr; bus.COLBK = bk;
    bus.COLPF0 = p0; bus.COLPF1 = p1; bus.COLPF2 = p2; bus.COLPF3 = p3;
    pf[0] = p0; pf[1] = p1; pf[2] = p2; pf[3] = p3;
    e.c1 = 8'h00; e.c2 = 8'h00; e.valid = 0; e.hs = 0; e.fs = 0;
    if (code == 3'b001 || code == 3'b011) begin
      if (!in_vsync) begin
        e.fs = 1; m_v = 0;
      end
      synced = 1; in_vsync = 1; in_blank = 0;
    end else if (!synced) begin
      // ignored until the first vertical sync
    end else if (code == 3'b010) begin
      if (!in_vsync && !in_blank) begin
        e.hs = 1;
        m_v = (m_v + 1 > 511) ? 511 : m_v + 1;
      end
      in_vsync = 0; in_blank = 1;
    end else begin
      if (in_vsync || in_blank) m_h = 0;
      else m_h = (m_h + 1 > 255) ? 255 : m_h + 1;
      in_vsync = 0; in_blank = 0;
      e.valid = 1;
      on_c = {p2[7:4], p1[3:0]};
      if (code == 3'b000) begin
        e.c1 = bk; e.c2 = bk;
      end else if (hr) begin
        e.c1 = code[1] ? on_c : p2;
        e.c2 = code[0] ? on_c : p2;
      end else begin
        e.c1 = pf[code[1:0]]; e.c2 = e.c1;
      end
    end
    e.hp = m_h[7:0];
    e.vp = m_v[8:0];
    sb.push_back(e);
  endtask

  task automatic drive(input logic [2:0] code, input logic hr);
    drive_col(code, hr, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  function automatic logic [2:0] rand_pixel();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 3'b000 : (3'b100 | 3'(r));
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_color"},  bus.colorOut,   8'h00);
    check({tag, "_color2"}, bus.colorOut2,  8'h00);
    check({tag, "_valid"},  bus.pixelValid, 1'b0);
    check({tag, "_hsync"},  bus.hsync,      1'b0);
    check({tag, "_frame"},  bus.frameStart, 1'b0);
    check({tag, "_hpos"},   bus.hpos,       8'h00);
    check({tag, "_vpos"},   bus.vpos,       9'h000);
  endtask

  always @(posedge Fphi0) begin
    #1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("colorOut",   bus.colorOut,   got.c1);
      check("colorOut2",  bus.colorOut2,  got.c2);
      check("pixelValid", bus.pixelValid, got.valid);
      check("hsync",      bus.hsync,      got.hs);
      check("frameStart", bus.frameStart, got.fs);
      check("hpos",       bus.hpos,       got.hp);
      check("vpos",       bus.vpos,       got.vp);
    end
  end

  initial begin
    RST_L = 1'b0;
    bus.AN = 3'b100; bus.hires = 0; bus.COLBK = 8'h11;
    bus.COLPF0 = 8'h22; bus.COLPF1 = 8'h33; bus.COLPF2 = 8'h44; bus.COLPF3 = 8'h55;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(posedge Fphi0);
    #3 RST_L = 1'b1;

    // unsynchronised codes are ignored, then one frame pulse per VSYNC run
    for (int i = 0; i < 10; i++) drive(3'b100, 0);
    drive(3'b001, 0);
    drive(3'b001, 0);
    drive(3'b011, 0);

    drive_col(3'b000, 0, 8'h94, 8'h01, 8'h02, 8'h03, 8'h04);
    drive_col(3'b101, 0, 8'h55, 8'h01, 8'h0E, 8'h03, 8'h04);

    for (int i = 0; i < 40; i++) drive(rand_pixel(), 0);
    for (int i = 0; i < 3; i++) drive(3'b010, 0);

    for (int l = 0; l < 600; l++) begin
      drive(rand_pixel(), 0);
      drive(rand_pixel(), 0);
      drive(3'b010, 0);
    end
    for (int i = 0; i < 300; i++) drive(rand_pixel(), 0);
    @(posedge Fphi0);
    #2;
    check("hpos_sat", bus.hpos, 8'hFF);
    check("vpos_sat", bus.vpos, 9'h1FF);

    drive_col(3'b110, 1, 8'h00, 8'h00, 8'h0A, 8'h94, 8'h00);
    drive_col(3'b111, 1, 8'h00, 8'h00, 8'h0A, 8'h94, 8'h00);
    drive_col(3'b000, 1, 8'h7C, 8'h00, 8'h0A, 8'h94, 8'h00);

    // asynchronous reset mid-line, after the scoreboard has taken the last pixel
    @(posedge Fphi0);
    #3;
    check("pre_reset_valid", bus.pixelValid, 1'b1);
    RST_L = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(posedge Fphi0);
    #3 RST_L = 1'b1;
    drive(3'b100, 0);
    drive(3'b010, 0);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [2:0] code;
      r = $urandom_range(0, 15);
      if (r == 0) code = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'b001;
      else if (r < 3) code = 3'b010;
      else code = rand_pixel();
      drive(code, 1'($urandom_range(0, 1)));
    end

    @(posedge Fphi0);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
